// File: rtl/bias_load_ctrl_pkg.sv
// Shared types and defaults for the bias load sequencer and its bias store.
package bias_ctrl_pkg;

    localparam int N_BIAS_DEF = 20;              // bias entries loaded per sequence
    localparam int DW_DEF     = 10;              // bias word width
    localparam int AW_DEF     = 5;               // address width, 2^AW >= N_BIAS
    localparam int LAST_IDX   = N_BIAS_DEF - 1;  // highest address ever written

    // Sequencer states; also exported on the debug port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bias_load_ctrl_if.sv
// Bias word stream into the load sequencer.
//
// Handshake: the producer raises in_valid with in_data and holds both
// stable until a rising clk edge where in_valid && in_ready is true; that
// edge transfers exactly one word. in_ready may be high without in_valid
// and carries no obligation. The producer may drop in_valid at any time.
interface bias_load_ctrl_if
    import bias_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/bias_memory.sv
// N x DW bias store: one synchronous write port, and a read strobe that
// copies the whole array onto the parallel outputs at once.
// data[i] is the dataI output of the store. Contents have no reset so a
// controller reset leaves partially written entries in place.
module bias_memory
    import bias_ctrl_pkg::*;
#(
    parameter int N  = N_BIAS_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic [DW-1:0]        datain,
    input  logic [AW-1:0]        addr,
    input  logic                 wt,
    input  logic                 rd,
    output logic [N-1:0][DW-1:0] data
);

    logic [N-1:0][DW-1:0] mem_q, mem_d;
    logic [N-1:0][DW-1:0] data_q, data_d;

    // Next contents: write one entry on wt, refresh all outputs on rd.
    always_comb begin
        mem_d  = mem_q;
        data_d = data_q;
        if (wt && (32'(addr) < N)) begin
            mem_d[addr] = datain;
        end
        if (rd) begin
            data_d = mem_q;
        end
    end

    // Storage and output registers.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/bias_load_ctrl.sv
// Sequencer owning the bias_memory write/read port: streams N_BIAS words
// into addresses 0..N_BIAS-1, then issues one read strobe and pulses done.
// Also serves stand-alone refresh requests. Write and read strobes are
// never asserted in the same cycle: FLUSH separates the last write from READ.
module bias_load_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int N_BIAS = N_BIAS_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            rd_req,
    input  logic            abort,
    bias_load_ctrl_if.slave s_in,
    output logic [DW-1:0]   mem_datain,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wt,
    output logic            mem_rd,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [AW-1:0]   wr_count,
    output state_t          dbg_state
);

    // Index of the final beat; accepting it ends the LOAD phase, so the
    // counter never advances past N_BIAS within a sequence.
    localparam logic [AW-1:0] LAST_BEAT = AW'(N_BIAS - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   datain_q, datain_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wt_q, wt_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            accept;

    // A word is taken only while loading and never in an abort cycle.
    assign s_in.in_ready = (state_q == LOAD) && !abort;
    assign accept        = s_in.in_valid && s_in.in_ready;

    // Next state, write-port capture and registered status outputs.
    always_comb begin
        state_d   = state_q;
        datain_d  = datain_q;
        addr_d    = addr_q;
        wt_d      = 1'b0;
        aborted_d = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (rd_req) begin
                    state_d = READ;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (accept) begin
                    datain_d = s_in.in_data;
                    addr_d   = cnt_q;
                    wt_d     = 1'b1;
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            READ:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and status follow the state being entered, so they are
        // registered yet line up with that state's cycle.
        rd_d   = (state_d == READ);
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // Single state/output register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            datain_q  <= '0;
            addr_q    <= '0;
            wt_q      <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            datain_q  <= datain_d;
            addr_q    <= addr_d;
            wt_q      <= wt_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_datain = datain_q;
    assign mem_addr   = addr_q;
    assign mem_wt     = wt_q;
    assign mem_rd     = rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign wr_count   = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Bench for bias_load_ctrl driving the real bias_memory downstream.
module tb_bias_load_ctrl;
    import bias_ctrl_pkg::*;

    localparam int N  = N_BIAS_DEF;
    localparam int DW = DW_DEF;
    localparam int AW = AW_DEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n, start, rd_req, abort;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0]        mem_datain;
    logic [AW-1:0]        mem_addr;
    logic                 mem_wt, mem_rd, busy, done, aborted;
    logic [AW-1:0]        wr_count;
    state_t               dbg_state;
    logic [N-1:0][DW-1:0] mem_data;

    bias_load_ctrl_if #(.DW(DW)) s_bus ();

    bias_load_ctrl #(.N_BIAS(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_req(rd_req), .abort(abort),
        .s_in(s_bus.slave),
        .mem_datain(mem_datain), .mem_addr(mem_addr), .mem_wt(mem_wt), .mem_rd(mem_rd),
        .busy(busy), .done(done), .aborted(aborted), .wr_count(wr_count),
        .dbg_state(dbg_state)
    );

    bias_memory #(.N(N), .DW(DW), .AW(AW)) u_mem (
        .clk(clk), .datain(mem_datain), .addr(mem_addr), .wt(mem_wt), .rd(mem_rd),
        .data(mem_data)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];          // {addr, word} of each expected write
    logic [DW-1:0]    exp_mem[N];        // expected store contents
    int n_wt = 0, n_rd = 0, n_done = 0, n_abort = 0;
    int rd_cyc = 0, done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observes the memory port every cycle: exclusivity, address bound,
    // write order against the expected queue, and event timestamps.
    task automatic monitor();
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_wt || mem_rd)
                    check("wt_rd_excl", 32'(mem_wt && mem_rd), 0);
                if (mem_wt) begin
                    n_wt++;
                    check("addr_bound", 32'(32'(mem_addr) <= LAST_IDX), 1);
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = 'x;
                    check("wr_beat", 32'({mem_addr, mem_datain}), 32'(e));
                end
                if (mem_rd) begin n_rd++; rd_cyc = cyc; end
                if (done) begin n_done++; done_cyc = cyc; end
                if (aborted) n_abort++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; abort = 1'b0;
        s_bus.in_valid = 1'b0; s_bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_mem%0d", tag, i), 32'(mem_data[i]), 32'(exp_mem[i]));
    endtask

    // One load sequence. word_mode 0: 0x3FF,1,2..; 1: random words.
    // stall_mode 0: valid every cycle; 1: valid toggles 1/0; 2: random.
    // abort_at >= 0: abort raised together with the valid beat of that index.
    task automatic load_seq(input int word_mode, input int stall_mode,
                            input int abort_at, input bit with_rd);
        int s_wt = n_wt, s_rd = n_rd, s_done = n_done, s_ab = n_abort;
        int acc = 0, last_cyc = 0, st_cyc, guard;
        bit v, tgl = 1'b0, was_aborted = 1'b0;
        logic [DW-1:0] w;

        @(posedge clk); #1;
        start = 1'b1; rd_req = with_rd; st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; rd_req = 1'b0;

        while (acc < N) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       begin v = ~tgl; tgl = ~tgl; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (word_mode == 0) w = (acc == 0) ? DW'(10'h3FF) : DW'(acc);
            else                w = DW'($urandom_range(0, 1023));

            if (v && acc == abort_at) begin
                abort = 1'b1; s_bus.in_valid = 1'b1; s_bus.in_data = w;
                @(negedge clk);
                check("ready_in_abort", 32'(s_bus.in_ready), 0);
                @(posedge clk); #1;
                abort = 1'b0; s_bus.in_valid = 1'b0;
                was_aborted = 1'b1;
                break;
            end

            s_bus.in_valid = v; s_bus.in_data = w;
            if (v) begin
                exp_q.push_back({AW'(acc), w});
                exp_mem[acc] = w;
                last_cyc = cyc;
                acc++;
            end
            @(negedge clk);
            check("ready_in_load", 32'(s_bus.in_ready), 1);
            @(posedge clk); #1;
        end
        s_bus.in_valid = 1'b0;

        if (was_aborted) begin
            @(negedge clk);
            check("aborted_pulse", 32'(aborted), 1);
            check("busy_after_abort", 32'(busy), 0);
            repeat (6) @(posedge clk);
            #1;
            check("abort_no_done", 32'(n_done - s_done), 0);
            check("abort_no_rd", 32'(n_rd - s_rd), 0);
            check("abort_pulses", 32'(n_abort - s_ab), 1);
            check("abort_writes", 32'(n_wt - s_wt), 32'(acc));
            check("abort_wr_count", 32'(wr_count), 32'(acc));
        end else begin
            guard = 0;
            while (n_done == s_done && guard < 40) begin
                @(posedge clk);
                guard++;
            end
            check("done_seen", 32'(n_done - s_done), 1);
            check("rd_latency", 32'(rd_cyc - last_cyc), 2);
            check("done_latency", 32'(done_cyc - last_cyc), 3);
            if (stall_mode == 0)
                check("done_cycle", 32'(done_cyc - st_cyc), 23);
            repeat (4) @(posedge clk);
            #1;
            check("load_done_count", 32'(n_done - s_done), 1);
            check("load_rd_count", 32'(n_rd - s_rd), 1);
            check("load_writes", 32'(n_wt - s_wt), N);
            check("load_wr_count", 32'(wr_count), N);
            check("load_idle", 32'(busy), 0);
            check("load_q_empty", 32'(exp_q.size()), 0);
            check_mem("load");
        end
    endtask

    // Stand-alone refresh: mem_rd one cycle after rd_req, done next, then idle.
    task automatic refresh();
        int s_wt = n_wt;
        @(posedge clk); #1;
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        check("ref_rd", 32'(mem_rd), 1);
        check("ref_wt", 32'(mem_wt), 0);
        check("ref_busy", 32'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ref_done", 32'(done), 1);
        check("ref_rd_off", 32'(mem_rd), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ref_idle", 32'(busy), 0);
        check("ref_done_off", 32'(done), 0);
        check("ref_no_wt", 32'(n_wt - s_wt), 0);
        check_mem("refresh");
    endtask

    // Reset asserted while the 12th beat is offered and the 11th is being written.
    task automatic reset_mid_load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_bus.in_valid = 1'b1;
            s_bus.in_data  = DW'($urandom_range(0, 1023));
            if (i < 11) begin
                exp_q.push_back({AW'(i), s_bus.in_data});
                @(posedge clk); #1;
            end
        end
        #1;
        check("wt_before_rst", 32'(mem_wt), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_wt", 32'(mem_wt), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_datain", 32'(mem_datain), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_in_ready", 32'(s_bus.in_ready), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        s_bus.in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fork
            monitor();
        join_none

        do_reset();
        @(negedge clk);
        check("init_mem_wt", 32'(mem_wt), 0);
        check("init_mem_rd", 32'(mem_rd), 0);
        check("init_mem_addr", 32'(mem_addr), 0);
        check("init_mem_datain", 32'(mem_datain), 0);
        check("init_busy", 32'(busy), 0);
        check("init_done", 32'(done), 0);
        check("init_aborted", 32'(aborted), 0);
        check("init_wr_count", 32'(wr_count), 0);
        check("init_in_ready", 32'(s_bus.in_ready), 0);
        check("init_state", 32'(dbg_state), 32'(IDLE));

        load_seq(0, 0, -1, 1'b0);          // fixed pattern, no stalls
        load_seq(1, 1, -1, 1'b0);          // valid toggling
        load_seq(1, 0, 7, 1'b0);           // abort with an 8th beat offered
        refresh();                         // addr 7..19 keep previous words
        load_seq(1, 0, -1, 1'b1);          // start and rd_req together

        // abort in IDLE has no effect
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle_pulse", 32'(aborted), 0);
        check("abort_idle_busy", 32'(busy), 0);

        reset_mid_load();
        load_seq(1, 0, -1, 1'b0);          // reload from addr 0 after reset

        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 1) begin
                load_seq(1, 2, $urandom_range(0, N - 2), 1'b0);
                refresh();
            end else begin
                load_seq(1, 2, -1, 1'b0);
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bias_load_ctrl.md
# bias_load_ctrl

Sequencer that owns the write/read port of `bias_memory` (20 × 10-bit bias store). It accepts a stream of bias words over a valid/ready handshake and writes them to consecutive addresses 0..N_BIAS-1. It then issues a single read strobe so `data0..data19` refresh, and pulses `done`. It also services stand-alone refresh requests from the layer datapath, and guarantees `wt` and `rd` are never asserted together.

## Interface
- `N_BIAS`, default 20: number of bias entries loaded per sequence.
- `DW`, default 10: bias word width.
- `AW`, default 5: address width; must satisfy 2^AW ≥ N_BIAS.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a full load sequence; sampled only in IDLE.
- `rd_req`  in  1  refresh memory outputs without loading; sampled only in IDLE.
- `abort`  in  1  cancel a load in progress.
- `in_valid`  in  1  bias word present.
- `in_data`  in  DW  bias word.
- `in_ready`  out  1  controller accepts a word (combinational: state==LOAD && !abort).
- `mem_datain`  out  DW  to `bias_memory.datain`; registered.
- `mem_addr`  out  AW  to `bias_memory.addr`; registered.
- `mem_wt`  out  1  to `bias_memory.wt`; registered.
- `mem_rd`  out  1  to `bias_memory.rd`; registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `aborted`  out  1  one-cycle pulse when a load is cancelled.
- `wr_count`  out  AW  number of words written in the current or last sequence.

## Operation
- States:
  - IDLE → LOAD on `start`; `start` has priority over `rd_req`.
  - IDLE → READ on `rd_req` && !`start`.
  - LOAD → FLUSH when beat N_BIAS-1 is accepted.
  - FLUSH → READ.
  - READ → DONE.
  - DONE → IDLE.
  - LOAD or FLUSH → IDLE on `abort`.
- Beat acceptance:
  - A beat is accepted when `in_valid && in_ready`.
  - The accepted word is registered to `mem_datain`, and `mem_addr` = beat index.
  - `mem_wt` = 1 for exactly the following cycle.
  - The beat index counter and `wr_count` increment per accepted beat.
- Stalls: `in_valid` low in LOAD holds the state indefinitely; there is no timeout.
- Counter reset: entering LOAD clears the beat counter and `wr_count` to 0.
- Strobe exclusivity:
  - `mem_rd` = 1 only during READ, and `mem_wt` is 0 in that cycle.
  - FLUSH exists so the last write cycle never coincides with `mem_rd`.
- Outputs in DONE: `done` = 1 and `busy` = 1.
- Abort:
  - `abort` during LOAD or FLUSH forces state to IDLE next edge and pulses `aborted` in that next cycle.
  - A beat offered in the abort cycle is not accepted (`in_ready` = 0).
  - A write already registered (`mem_wt` = 1 in the abort cycle) completes.
  - `done` is not pulsed on abort.
  - `abort` in IDLE, READ or DONE is ignored.
- `start`/`rd_req` outside IDLE are ignored, not queued.
- Address bound: `mem_addr` never exceeds N_BIAS-1; the counter does not wrap within a sequence.

## Timing
- Reset values: state IDLE; `mem_datain` = 0, `mem_addr` = 0, `mem_wt` = 0, `mem_rd` = 0, `busy` = 0, `done` = 0, `aborted` = 0, `wr_count` = 0.
- `in_ready` = 0 in reset.
- Full load, no stalls, `start` high at cycle 0:
  - Cycles 1..20: LOAD, one beat accepted per cycle.
  - Cycles 2..21: `mem_wt` high, addr 0..19.
  - Cycle 21: FLUSH.
  - Cycle 22: READ, `mem_rd` = 1.
  - Cycle 23: `done` = 1.
  - Cycle 24: IDLE.
  - Latency from the last accepted beat to `done`: 3 cycles.
- Refresh only, `rd_req` at cycle 0: `mem_rd` at cycle 1, `done` at cycle 2, IDLE at cycle 3.
- `rst_n` low mid-sequence:
  - All registers return to reset values immediately.
  - `mem_wt`/`mem_rd` drop without waiting for a clock.
  - Partial memory contents remain as written.

## Structure
- Package `bias_ctrl_pkg`: state enum (IDLE, LOAD, FLUSH, READ, DONE), defaults for N_BIAS/DW/AW, localparam `LAST_IDX` = N_BIAS-1.
- Single module. No sub-module is required; the beat counter is inline.
- Testbench instantiates the real `bias_memory` downstream and checks `data0..data19`.

## Test plan
- Full load, no stalls: `start`, then words 0x3FF, 0x001, 0x002..0x013 back-to-back → memory holds those values at addr 0..19; `done` at cycle 23; `wr_count` = 20.
- Back-pressure: `in_valid` toggling 1/0 each cycle → 20 writes, in order, no duplicates; `done` 3 cycles after the 20th accepted beat.
- Abort after 7 beats, with `abort` coinciding with an 8th valid beat → `aborted` pulse, `wr_count` = 7, addr 7 unwritten, no `done`, no `mem_rd`.
- `rd_req` alone in IDLE → one `mem_rd` cycle with `mem_wt` = 0, then `done`; `start` and `rd_req` in the same cycle → LOAD entered, `rd_req` dropped.
- `rst_n` asserted during beat 12 → all outputs 0 asynchronously; a subsequent `start` reloads from addr 0.
- Property checks across all tests: never `mem_wt` && `mem_rd`; `mem_addr` ≤ 19 whenever `mem_wt` = 1.
